// File: rtl/mem_stage.sv
// mem_stage: rv32 memory-access stage that runs loads/stores over a Wishbone-style bus
//   parameters : XLEN datapath width, TIMEOUT bus cycles without ack/err before a timeout (0 = never)
//   clk, rst   : rising-edge clock, asynchronous active-low reset
//   in_*       : EX/MEM slot (valid, address/ALU result, store data, load/store, funct3, rd write/number)
//   stall_o    : hold EX/MEM while an access is outstanding
//   mem_*      : registered bus master outputs, mem_dat_i/mem_ack_i/mem_err_i responses
//   out_*      : MEM/WB results, extended load data, exception pulse and cause
module mem_stage #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_aluresult,
  input  logic [XLEN-1:0] in_store_data,
  input  logic            in_mem_load,
  input  logic            in_mem_store,
  input  logic [2:0]      in_funct3,
  input  logic            in_reg_wr,
  input  logic [4:0]      in_reg_wnum,
  output logic            stall_o,
  output logic            mem_cyc_o,
  output logic            mem_stb_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic [3:0]      mem_sel_o,
  output logic [XLEN-1:0] mem_dat_o,
  input  logic [XLEN-1:0] mem_dat_i,
  input  logic            mem_ack_i,
  input  logic            mem_err_i,
  output logic [XLEN-1:0] out_aluresult,
  output logic [XLEN-1:0] out_mem_dat_i_w,
  output logic            out_mem_load,
  output logic            out_reg_wr,
  output logic [4:0]      out_reg_wnum,
  output logic            out_exc,
  output logic [1:0]      out_exc_cause
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, BUS} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            cyc_q, we_q;
  logic [XLEN-1:0] adr_q, adr_d, dat_q, dat_d, ext;
  logic [3:0]      sel_q, sel_d;
  logic [1:0]      a;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic            mem_op, is_b, is_h, mis, busy, tmo, done, bad, ld_ok;
  assign a      = in_aluresult[1:0];
  assign mem_op = in_valid & (in_mem_load | in_mem_store);
  // funct3[2] only selects zero-extension for loads; for stores it is unsupported and falls back to word
  assign is_b   = (in_funct3[1:0] == 2'b00) & (in_mem_load | ~in_funct3[2]);
  assign is_h   = (in_funct3[1:0] == 2'b01) & (in_mem_load | ~in_funct3[2]);
  assign mis    = mem_op & (is_h ? a[0] : (~is_b & (a != 2'b00)));
  assign busy   = state_q == BUS;
  assign tmo    = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign done   = busy & (mem_err_i | mem_ack_i | tmo);
  // err beats ack; an ack arriving on the timeout cycle still completes normally
  assign bad    = busy & (mem_err_i | (~mem_ack_i & tmo));
  assign ld_ok  = busy & mem_ack_i & ~mem_err_i & ~we_q;
  assign lane_b = mem_dat_i[8*a +: 8];
  assign lane_h = mem_dat_i[16*a[1] +: 16];
  assign ext    = is_b ? {{(XLEN-8){lane_b[7] & ~in_funct3[2]}}, lane_b}
                : is_h ? {{(XLEN-16){lane_h[15] & ~in_funct3[2]}}, lane_h} : mem_dat_i;
  assign adr_d  = {in_aluresult[XLEN-1:2], 2'b00};
  assign sel_d  = in_mem_load ? 4'b1111 : is_b ? 4'b0001 << a : is_h ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dat_d  = is_b ? {(XLEN/8){in_store_data[7:0]}} : is_h ? {(XLEN/16){in_store_data[15:0]}} : in_store_data;
  assign mem_cyc_o       = cyc_q;
  assign mem_stb_o       = cyc_q;
  assign mem_we_o        = we_q;
  assign mem_adr_o       = adr_q;
  assign mem_sel_o       = sel_q;
  assign mem_dat_o       = dat_q;
  assign stall_o         = rst & (busy ? ~done : mem_op & ~mis);
  assign out_reg_wr      = rst & (busy ? ld_ok & in_reg_wr : in_valid & in_reg_wr & ~in_mem_load & ~in_mem_store);
  assign out_mem_load    = rst & ld_ok;
  assign out_mem_dat_i_w = (rst & ld_ok) ? ext : '0;
  assign out_exc         = rst & (busy ? bad : mis);
  assign out_exc_cause   = ~rst ? 2'b00 : busy ? (bad ? 2'b11 : 2'b00) : mis ? (in_mem_load ? 2'b01 : 2'b10) : 2'b00;
  assign out_aluresult   = rst ? in_aluresult : '0;
  assign out_reg_wnum    = rst ? in_reg_wnum : 5'd0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= 4'b0000;
      dat_q   <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        state_q <= IDLE;
        cyc_q   <= 1'b0;
        we_q    <= 1'b0;
      end
    end else if (mem_op & ~mis) begin
      state_q <= BUS;
      cnt_q   <= '0;
      cyc_q   <= 1'b1;
      we_q    <= in_mem_store;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the rv32 pipeline: takes the instruction held in the EX/MEM slot, performs loads and stores over a single-master Wishbone-style data bus, and presents the result to the MEM/WB pipeline register. It extracts and extends loaded data, generates byte selects for stores, and detects misaligned accesses. It detects bus errors and ack timeouts, and stalls upstream while an access is outstanding.

## Interface
- XLEN, 32, datapath width
- TIMEOUT, 255, cycles in BUS without ack/err before a timeout error; 0 disables timeout
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  EX/MEM slot holds a live instruction
- in_aluresult  in  XLEN  ALU result / effective address
- in_store_data  in  XLEN  rs2 value for stores
- in_mem_load, in_mem_store  in  1 each  load / store (never both)
- in_funct3  in  3  access size/sign
- in_reg_wr  in  1  instruction writes rd
- in_reg_wnum  in  5  rd
- stall_o  out  1  upstream must hold EX/MEM contents
- mem_cyc_o, mem_stb_o, mem_we_o  out  1 each  bus cycle, strobe, write enable
- mem_adr_o  out  XLEN  word address; bits [1:0] always 0
- mem_sel_o  out  4  byte lanes
- mem_dat_o  out  XLEN  write data
- mem_dat_i  in  XLEN  read data
- mem_ack_i, mem_err_i  in  1 each  bus completion / error
- out_aluresult  out  XLEN  to MEM/WB
- out_mem_dat_i_w  out  XLEN  extended load data
- out_mem_load  out  1  completed load this cycle
- out_reg_wr  out  1  write rd this cycle
- out_reg_wnum  out  5  rd
- out_exc  out  1  exception pulse
- out_exc_cause  out  2  01 load misaligned, 10 store misaligned, 11 bus error/timeout

## Operation
- FSM states IDLE, BUS. Timeout counter clog2(TIMEOUT+1) bits, cleared on entering BUS.
- Non-memory instruction (IDLE): combinational pass-through; out_reg_wr = in_valid & in_reg_wr; out_mem_load 0; stall_o 0.
- Misalignment: half with addr[0]=1, word with addr[1:0]≠0. No bus access, no state change; out_exc=1, cause 01/10, out_reg_wr 0, stall_o 0, same cycle.
- Aligned memory op in IDLE: stall_o=1, out_reg_wr=0. On the edge, register adr={addr[31:2],2'b00}, sel, dat, we=store, cyc=stb=1; go BUS.
- Store lanes: 000 sb: sel=1<<addr[1:0], data = byte replicated x4; 001 sh: sel 0011/1100 by addr[1], data = half replicated x2; 010 sw: 1111. Unsupported funct3 treated as word.
- Load extract by addr[1:0]: 000 lb sign-extend, 001 lh sign-extend, 100 lbu, 101 lhu zero-extend, 010/other word.
- BUS: cyc/stb held. Completion cycle = mem_err_i, or mem_ack_i, or counter==TIMEOUT-1 (TIMEOUT>0). In that cycle stall_o=0 and the outputs are driven.
  - ack: out_reg_wr = in_reg_wr for loads, 0 for stores. out_mem_load = load. out_mem_dat_i_w = extended mem_dat_i.
  - err or timeout: out_exc=1, cause 11, out_reg_wr 0.
  - FSM returns to IDLE and cyc/stb/we clear on that edge.
- err and ack in the same cycle: err wins. ack/err while IDLE: ignored.
- out_aluresult and out_reg_wnum always follow inputs. out_mem_dat_i_w is 0 except on load completion. out_exc is 0 except as above.

## Timing
- While rst low: FSM IDLE, counter 0, all bus outputs 0, all outputs forced 0 including stall_o.
- Reset asserted mid-BUS: cyc/stb drop immediately. A later ack is ignored.
- Non-memory: 0 extra cycles. Memory op: issue cycle + ≥1 BUS cycle. Zero-wait ack gives 2 cycles, stall_o high for exactly 1.
- Bus outputs are registered. mem_adr_o/sel/dat/we are stable throughout BUS.
- Back-to-back memory ops: the second issues in the cycle after completion. cyc drops for ≥1 cycle between accesses.

## Test plan
- Reset: rst low with in_valid=1, in_mem_load=1 -> every output 0. After release, first load issues cleanly.
- ALU op in_aluresult=0x1234, reg_wr=1, wnum=5 -> same-cycle out_reg_wr=1, out_aluresult=0x1234, stall_o=0.
- lb addr 0x1003, ack after 3 wait cycles with mem_dat_i=0x80AABBCC -> adr 0x1000, sel 1111, we 0, stall_o high 4 cycles, out_mem_dat_i_w=0xFFFFFF80, out_mem_load=1.
- sh addr 0x2002 data 0x0000BEEF -> sel 1100, mem_dat_o 0xBEEFBEEF, we 1, zero-wait ack, out_reg_wr 0.
- lw addr 0x1002 -> cause 01, no cyc. sw addr 0x3001 -> cause 10, no cyc.
- TIMEOUT=4, no ack -> exc cause 11 on 4th BUS cycle, cyc low next cycle. Separately, ack+err together -> cause 11. Reset mid-BUS -> cyc low immediately, later ack ignored.
